// File: rtl/i2c_txn_pkg.sv
// rtl/i2c_txn_pkg.sv - shared types and width helpers for the I2C transaction sequencer
//
// Contents:
//   state_e          sequencer FSM state encoding
//   clog2_int/max_int  elaboration-time width helpers
//   cnt_width        byte-count field width, max(1, clog2(max_burst))
//   rty_width        retry-count field width, max(1, clog2(retry_limit+1))
//   lvl_width        FIFO level width, clog2(depth)+1
//   entry_width      packed command entry width
//   Command entry layout (LSB first): addr[6:0], rd_wrn, wr_count, rd_count, wdata
package i2c_txn_pkg;

    localparam int ADDR_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return max_int(1, clog2_int(max_burst));
    endfunction

    function automatic int rty_width(input int retry_limit);
        return max_int(1, clog2_int(retry_limit + 1));
    endfunction

    function automatic int lvl_width(input int depth);
        return clog2_int(depth) + 1;
    endfunction

    function automatic int entry_width(input int max_burst);
        return ADDR_W + 1 + 2 * cnt_width(max_burst) + 8 * max_burst;
    endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// rtl/i2c_txn_sequencer_if.sv - command, response and I2C-master handshake bundle
//
// Groups every non-clock/reset signal of i2c_txn_sequencer.
//   slave  modport: sequencer view (accepts commands, drives responses and master requests)
//   master modport: environment view (register map + I2C master side)
// Signal groups:
//   i_cmd_*  / o_cmd_ready   command push into the FIFO
//   o_rsp_*  / i_rsp_ready   response to the register map
//   o_m_*    / i_m_ready     request to the I2C master
//   i_m_rsp_* / o_m_rsp_ready completion from the I2C master
//   o_cmd_level, o_busy      status
interface i2c_txn_sequencer_if
    import i2c_txn_pkg::*;
#(
    parameter int MaxBurst   = 4,
    parameter int CmdDepth   = 4,
    parameter int RetryLimit = 3
) ();

    localparam int CntW = cnt_width(MaxBurst);
    localparam int RtyW = rty_width(RetryLimit);
    localparam int LvlW = lvl_width(CmdDepth);
    localparam int DatW = 8 * MaxBurst;

    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [ADDR_W-1:0]   i_cmd_addr;
    logic                i_cmd_rd_wrn;
    logic [CntW-1:0]     i_cmd_wr_count;
    logic [CntW-1:0]     i_cmd_rd_count;
    logic [DatW-1:0]     i_cmd_wdata;

    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic                o_rsp_nack;
    logic [RtyW-1:0]     o_rsp_retries;
    logic [DatW-1:0]     o_rsp_rdata;

    logic                o_m_valid;
    logic                i_m_ready;
    logic [ADDR_W-1:0]   o_m_addr;
    logic                o_m_rd_wrn;
    logic [CntW-1:0]     o_m_wr_count;
    logic [CntW-1:0]     o_m_rd_count;
    logic [DatW-1:0]     o_m_wdata;

    logic                i_m_rsp_valid;
    logic                o_m_rsp_ready;
    logic                i_m_rsp_nack;
    logic [DatW-1:0]     i_m_rsp_rdata;

    logic [LvlW-1:0]     o_cmd_level;
    logic                o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_addr, i_cmd_rd_wrn, i_cmd_wr_count, i_cmd_rd_count, i_cmd_wdata,
        output o_cmd_ready,
        output o_rsp_valid, o_rsp_nack, o_rsp_retries, o_rsp_rdata,
        input  i_rsp_ready,
        output o_m_valid, o_m_addr, o_m_rd_wrn, o_m_wr_count, o_m_rd_count, o_m_wdata,
        input  i_m_ready,
        input  i_m_rsp_valid, i_m_rsp_nack, i_m_rsp_rdata,
        output o_m_rsp_ready,
        output o_cmd_level, o_busy
    );

    modport master (
        output i_cmd_valid, i_cmd_addr, i_cmd_rd_wrn, i_cmd_wr_count, i_cmd_rd_count, i_cmd_wdata,
        input  o_cmd_ready,
        input  o_rsp_valid, o_rsp_nack, o_rsp_retries, o_rsp_rdata,
        output i_rsp_ready,
        input  o_m_valid, o_m_addr, o_m_rd_wrn, o_m_wr_count, o_m_rd_count, o_m_wdata,
        output i_m_ready,
        output i_m_rsp_valid, i_m_rsp_nack, i_m_rsp_rdata,
        input  o_m_rsp_ready,
        input  o_cmd_level, o_busy
    );

endinterface

// File: rtl/i2c_txn_cmd_fifo.sv
// rtl/i2c_txn_cmd_fifo.sv - synchronous command FIFO with level output
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_push, i_push_data   write one entry (ignored when not ready)
//   i_pop            drop the head entry (ignored when empty)
//   o_head_data      current head entry, valid while o_level != 0
//   o_level          occupancy, 0..Depth
//   o_ready          registered "not full"; held 0 while in reset
module i2c_txn_cmd_fifo
    import i2c_txn_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [Width-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [Width-1:0]             o_head_data,
    output logic [lvl_width(Depth)-1:0]  o_level,
    output logic                         o_ready
);

    localparam int PtrW = clog2_int(Depth);
    localparam int LvlW = lvl_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             ready_q, ready_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push & ready_q;
    assign do_pop  = i_pop & (level_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_push_data;
            // Depth is a power of two, so the pointer wraps by overflow.
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Ready is registered from the next level so it never depends
        // combinationally on push/pop and reads 0 during reset.
        ready_d = (level_d != LvlW'(Depth));
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    assign o_head_data = mem_q[rd_ptr_q];
    assign o_level     = level_q;
    assign o_ready     = ready_q;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// rtl/i2c_txn_sequencer.sv - queued I2C transaction issue and NACK-retry engine
//
// Optional feature macro: I2C_RETRY_BACKOFF_EN (idle back-off before each re-issue).
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   bus      i2c_txn_sequencer_if.slave: command push, response, master request,
//            master completion, FIFO level and busy status
// Commands are queued in i2c_txn_cmd_fifo and issued one at a time; a NACKed
// transaction is re-issued up to RetryLimit times before the NACK is reported.
module i2c_txn_sequencer
    import i2c_txn_pkg::*;
#(
    parameter int MaxBurst      = 4,
    parameter int CmdDepth      = 4,
    parameter int RetryLimit    = 3,
    parameter int BackoffCycles = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    i2c_txn_sequencer_if.slave   bus
);

    localparam int CntW = cnt_width(MaxBurst);
    localparam int RtyW = rty_width(RetryLimit);
    localparam int LvlW = lvl_width(CmdDepth);
    localparam int DatW = 8 * MaxBurst;
    localparam int EntW = entry_width(MaxBurst);

    state_e            state_q, state_d;
    logic [RtyW-1:0]   retry_q, retry_d;
    logic              rsp_nack_q, rsp_nack_d;
    logic [RtyW-1:0]   rsp_retries_q, rsp_retries_d;
    logic [DatW-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef I2C_RETRY_BACKOFF_EN
    localparam int BoW = max_int(1, clog2_int(BackoffCycles));
    logic [BoW-1:0]    backoff_q, backoff_d;
`endif

    logic              fifo_ready;
    logic              fifo_pop;
    logic [EntW-1:0]   head;
    logic [LvlW-1:0]   level;

    logic [ADDR_W-1:0] head_addr;
    logic              head_rd_wrn;
    logic [CntW-1:0]   head_wr_count;
    logic [CntW-1:0]   head_rd_count;
    logic [DatW-1:0]   head_wdata;
    logic [DatW-1:0]   rdata_mask;

    logic              m_valid;
    logic              m_rsp_ready;
    logic              rsp_valid;

    i2c_txn_cmd_fifo #(
        .Width (EntW),
        .Depth (CmdDepth)
    ) u_cmd_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (bus.i_cmd_valid & fifo_ready),
        .i_push_data ({bus.i_cmd_wdata, bus.i_cmd_rd_count, bus.i_cmd_wr_count,
                       bus.i_cmd_rd_wrn, bus.i_cmd_addr}),
        .i_pop       (fifo_pop),
        .o_head_data (head),
        .o_level     (level),
        .o_ready     (fifo_ready)
    );

    assign head_addr     = head[ADDR_W-1:0];
    assign head_rd_wrn   = head[ADDR_W];
    assign head_wr_count = head[ADDR_W+1 +: CntW];
    assign head_rd_count = head[ADDR_W+1+CntW +: CntW];
    assign head_wdata    = head[ADDR_W+1+2*CntW +: DatW];

    // Keep only read bytes 0..rd_count; the master may return junk above that.
    always_comb begin
        rdata_mask = '0;
        for (int i = 0; i < MaxBurst; i++) begin
            if (CntW'(i) <= head_rd_count) begin
                rdata_mask[8*i +: 8] = 8'hFF;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        rsp_nack_d    = rsp_nack_q;
        rsp_retries_d = rsp_retries_q;
        rsp_rdata_d   = rsp_rdata_q;
        fifo_pop      = 1'b0;
        m_valid       = 1'b0;
        m_rsp_ready   = 1'b0;
        rsp_valid     = 1'b0;
`ifdef I2C_RETRY_BACKOFF_EN
        backoff_d     = backoff_q;
`endif
        case (state_q)
            ST_IDLE: begin
                retry_d = '0;
                if (level != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_valid = 1'b1;
                if (bus.i_m_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                m_rsp_ready = 1'b1;
                if (bus.i_m_rsp_valid) begin
                    if (bus.i_m_rsp_nack && (retry_q < RtyW'(RetryLimit))) begin
                        retry_d = retry_q + 1'b1;
`ifdef I2C_RETRY_BACKOFF_EN
                        backoff_d = BoW'(BackoffCycles - 1);
                        state_d   = ST_BACKOFF;
`else
                        state_d   = ST_ISSUE;
`endif
                    end else begin
                        rsp_nack_d    = bus.i_m_rsp_nack;
                        rsp_retries_d = retry_q;
                        rsp_rdata_d   = (bus.i_m_rsp_nack || !head_rd_wrn) ? '0
                                      : (bus.i_m_rsp_rdata & rdata_mask);
                        fifo_pop      = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
`ifdef I2C_RETRY_BACKOFF_EN
            ST_BACKOFF: begin
                if (backoff_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    backoff_d = backoff_q - 1'b1;
                end
            end
`endif
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (bus.i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            retry_q       <= '0;
            rsp_nack_q    <= 1'b0;
            rsp_retries_q <= '0;
            rsp_rdata_q   <= '0;
`ifdef I2C_RETRY_BACKOFF_EN
            backoff_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            rsp_nack_q    <= rsp_nack_d;
            rsp_retries_q <= rsp_retries_d;
            rsp_rdata_q   <= rsp_rdata_d;
`ifdef I2C_RETRY_BACKOFF_EN
            backoff_q     <= backoff_d;
`endif
        end
    end

    assign bus.o_cmd_ready   = fifo_ready;
    assign bus.o_cmd_level   = level;
    assign bus.o_busy        = (state_q != ST_IDLE) || (level != '0);

    // Head fields are only presented while a request is outstanding, so the
    // master bus reads all-zero when idle and straight after reset.
    assign bus.o_m_valid     = m_valid;
    assign bus.o_m_addr      = m_valid ? head_addr     : '0;
    assign bus.o_m_rd_wrn    = m_valid ? head_rd_wrn   : 1'b0;
    assign bus.o_m_wr_count  = m_valid ? head_wr_count : '0;
    assign bus.o_m_rd_count  = m_valid ? head_rd_count : '0;
    assign bus.o_m_wdata     = m_valid ? head_wdata    : '0;
    assign bus.o_m_rsp_ready = m_rsp_ready;

    assign bus.o_rsp_valid   = rsp_valid;
    assign bus.o_rsp_nack    = rsp_nack_q;
    assign bus.o_rsp_retries = rsp_retries_q;
    assign bus.o_rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb/tb_i2c_txn_sequencer.sv - directed self-checking bench for i2c_txn_sequencer
module tb_i2c_txn_sequencer;
    import i2c_txn_pkg::*;

    localparam int MaxBurst      = 4;
    localparam int CmdDepth      = 4;
    localparam int RetryLimit    = 3;
    localparam int BackoffCycles = 8;
`ifdef I2C_RETRY_BACKOFF_EN
    localparam int ExpGap = BackoffCycles + 1;
`else
    localparam int ExpGap = 1;
`endif
    localparam int Bound = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_txn_sequencer_if #(
        .MaxBurst   (MaxBurst),
        .CmdDepth   (CmdDepth),
        .RetryLimit (RetryLimit)
    ) bus ();

    i2c_txn_sequencer #(
        .MaxBurst      (MaxBurst),
        .CmdDepth      (CmdDepth),
        .RetryLimit    (RetryLimit),
        .BackoffCycles (BackoffCycles)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [6:0] addr, input logic rd_wrn, input logic [1:0] wc,
                            input logic [1:0] rc, input logic [31:0] wd, output int acc_cyc);
        int n;
        n = 0;
        bus.i_cmd_valid    = 1'b1;
        bus.i_cmd_addr     = addr;
        bus.i_cmd_rd_wrn   = rd_wrn;
        bus.i_cmd_wr_count = wc;
        bus.i_cmd_rd_count = rc;
        bus.i_cmd_wdata    = wd;
        @(negedge clk);
        while (!bus.o_cmd_ready && n < Bound) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_timeout", 64'(n >= Bound), 64'd0);
        @(posedge clk);
        #1;
        acc_cyc = cyc - 1;
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic serve(input logic nack, input logic [31:0] rdata,
                         output int issue_cyc, output int done_cyc, output logic [6:0] addr_seen);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_m_valid && n < Bound) begin
            @(negedge clk);
            n++;
        end
        check_eq("issue_timeout", 64'(n >= Bound), 64'd0);
        issue_cyc = cyc;
        addr_seen = bus.o_m_addr;
        bus.i_m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_m_ready     = 1'b0;
        bus.i_m_rsp_valid = 1'b1;
        bus.i_m_rsp_nack  = nack;
        bus.i_m_rsp_rdata = rdata;
        @(posedge clk);
        #1;
        done_cyc = cyc - 1;
        bus.i_m_rsp_valid = 1'b0;
        bus.i_m_rsp_nack  = 1'b0;
        bus.i_m_rsp_rdata = '0;
    endtask

    task automatic get_rsp(input string tag, input logic exp_nack, input logic [1:0] exp_rty,
                           input logic [31:0] exp_rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_rsp_valid && n < Bound) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_rsp_timeout"}, 64'(n >= Bound), 64'd0);
        check_eq({tag, "_nack"}, 64'(bus.o_rsp_nack), 64'(exp_nack));
        check_eq({tag, "_retries"}, 64'(bus.o_rsp_retries), 64'(exp_rty));
        check_eq({tag, "_rdata"}, 64'(bus.o_rsp_rdata), 64'(exp_rd));
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rsp_ready = 1'b0;
    endtask

    initial begin
        int acc, iss, done, prev_done;
        logic [6:0] a;

        bus.i_cmd_valid    = 1'b0;
        bus.i_cmd_addr     = '0;
        bus.i_cmd_rd_wrn   = 1'b0;
        bus.i_cmd_wr_count = '0;
        bus.i_cmd_rd_count = '0;
        bus.i_cmd_wdata    = '0;
        bus.i_rsp_ready    = 1'b0;
        bus.i_m_ready      = 1'b0;
        bus.i_m_rsp_valid  = 1'b0;
        bus.i_m_rsp_nack   = 1'b0;
        bus.i_m_rsp_rdata  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
        check_eq("rst_m_valid", 64'(bus.o_m_valid), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check_eq("rst_level", 64'(bus.o_cmd_level), 64'd0);
        check_eq("rst_busy", 64'(bus.o_busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", 64'(bus.o_cmd_ready), 64'd1);

        // Write 0x74, two bytes, master ACKs; upper wdata bytes pass through.
        push_cmd(7'h74, 1'b0, 2'd1, 2'd0, 32'h1234_AA55, acc);
        @(negedge clk);
        check_eq("wr_busy", 64'(bus.o_busy), 64'd1);
        serve(1'b0, 32'hFFFF_FFFF, iss, done, a);
        check_eq("wr_issue_latency", 64'(iss - acc), 64'd2);
        check_eq("wr_addr", 64'(a), 64'h74);
        get_rsp("wr", 1'b0, 2'd0, 32'h0);

        // Field check while request is held.
        push_cmd(7'h74, 1'b0, 2'd1, 2'd0, 32'h1234_AA55, acc);
        repeat (2) @(negedge clk);
        check_eq("wr_m_valid", 64'(bus.o_m_valid), 64'd1);
        check_eq("wr_m_wdata", 64'(bus.o_m_wdata), 64'h1234_AA55);
        check_eq("wr_m_wr_count", 64'(bus.o_m_wr_count), 64'd1);
        check_eq("wr_m_rd_wrn", 64'(bus.o_m_rd_wrn), 64'd0);
        serve(1'b0, 32'h0, iss, done, a);
        get_rsp("wr2", 1'b0, 2'd0, 32'h0);

        // Full-burst read and a two-byte read with masking of upper bytes.
        push_cmd(7'h5D, 1'b1, 2'd0, 2'd3, 32'h0, acc);
        serve(1'b0, 32'hDEAD_BEEF, iss, done, a);
        check_eq("rd_addr", 64'(a), 64'h5D);
        get_rsp("rd4", 1'b0, 2'd0, 32'hDEAD_BEEF);
        push_cmd(7'h5D, 1'b1, 2'd0, 2'd1, 32'h0, acc);
        serve(1'b0, 32'hDEAD_BEEF, iss, done, a);
        get_rsp("rd2", 1'b0, 2'd0, 32'h0000_BEEF);

        // Two NACKs then ACK: three issues, retry gap per build.
        push_cmd(7'h22, 1'b1, 2'd0, 2'd3, 32'h0, acc);
        serve(1'b1, 32'h0, iss, prev_done, a);
        serve(1'b1, 32'h0, iss, done, a);
        check_eq("retry1_gap", 64'(iss - prev_done), 64'(ExpGap));
        prev_done = done;
        serve(1'b0, 32'h0102_0304, iss, done, a);
        check_eq("retry2_gap", 64'(iss - prev_done), 64'(ExpGap));
        get_rsp("retry", 1'b0, 2'd2, 32'h0102_0304);

        // Four NACKs: retries exhausted, NACK reported, rdata zeroed.
        push_cmd(7'h33, 1'b1, 2'd0, 2'd3, 32'h0, acc);
        for (int i = 0; i < 4; i++) begin
            serve(1'b1, 32'hCAFE_F00D, iss, done, a);
        end
        @(negedge clk);
        check_eq("exhaust_no_reissue", 64'(bus.o_m_valid), 64'd0);
        get_rsp("exhaust", 1'b1, 2'd3, 32'h0);

        // Fill the FIFO with the response stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            push_cmd(7'(8'h10 + i), 1'b1, 2'd0, 2'd3, 32'h0, acc);
        end
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = 7'h14;
        @(negedge clk);
        check_eq("full_level", 64'(bus.o_cmd_level), 64'd4);
        check_eq("full_ready", 64'(bus.o_cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve(1'b0, {24'hC0FFEE, 8'(8'h10 + i)}, iss, done, a);
            check_eq("order_addr", 64'(a), 64'(8'h10 + i));
            if (i == 0) begin
                push_cmd(7'h14, 1'b1, 2'd0, 2'd3, 32'h0, acc);
            end
            get_rsp("order", 1'b0, 2'd0, {24'hC0FFEE, 8'(8'h10 + i)});
        end

        // Reset while waiting for a completion.
        push_cmd(7'h41, 1'b1, 2'd0, 2'd3, 32'h0, acc);
        push_cmd(7'h42, 1'b0, 2'd0, 2'd0, 32'h0, acc);
        @(negedge clk);
        while (!bus.o_m_valid && (cyc - acc) < Bound) @(negedge clk);
        bus.i_m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_m_ready = 1'b0;
        check_eq("wait_rsp_ready", 64'(bus.o_m_rsp_ready), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstw_m_valid", 64'(bus.o_m_valid), 64'd0);
        check_eq("rstw_m_rsp_ready", 64'(bus.o_m_rsp_ready), 64'd0);
        check_eq("rstw_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check_eq("rstw_level", 64'(bus.o_cmd_level), 64'd0);
        check_eq("rstw_busy", 64'(bus.o_busy), 64'd0);
        check_eq("rstw_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_cmd(7'h55, 1'b1, 2'd0, 2'd2, 32'h0, acc);
        serve(1'b0, 32'h8877_6655, iss, done, a);
        check_eq("after_rst_latency", 64'(iss - acc), 64'd2);
        check_eq("after_rst_addr", 64'(a), 64'h55);
        get_rsp("after_rst", 1'b0, 2'd0, 32'h0077_6655);
        @(negedge clk);
        check_eq("final_busy", 64'(bus.o_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
